// File: rtl/adc_capture.sv
// Triggered multi-channel sample capture: decimated samples fill a ring buffer with
// pre-trigger history, then a ready/valid port reads out a DEPTH-record window.
module adc_capture #(
    parameter int N_CH       = 2,
    parameter int SIG_BITS   = 16,
    parameter int TIME_BITS  = 64,
    parameter int DEPTH      = 16,
    parameter int PRE_TRIG   = 4,
    parameter int DECIM_BITS = 8,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [TIME_BITS-1:0]       time_curr,
    input  logic [N_CH*SIG_BITS-1:0]   sig,
    input  logic                       valid_in,
    input  logic [DECIM_BITS-1:0]      decim,
    input  logic                       arm,
    input  logic                       force_trig,
    input  logic [CH_W-1:0]            trig_ch,
    input  logic [SIG_BITS-1:0]        trig_level,
    input  logic                       trig_fall,
    output logic [2:0]                 state,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [TIME_BITS-1:0]       rd_time,
    output logic [N_CH*SIG_BITS-1:0]   rd_sig,
    output logic                       rd_last,
    output logic                       done
);

    localparam int AW       = $clog2(DEPTH);
    localparam int REC_W    = TIME_BITS + N_CH*SIG_BITS;
    localparam int POST_CNT = DEPTH - PRE_TRIG - 1;

    localparam logic [AW-1:0] PRE_OFF   = AW'(PRE_TRIG);
    localparam logic [AW:0]   PRE_LAST  = (AW+1)'(PRE_TRIG - 1);
    localparam logic [AW:0]   POST_LAST = (AW+1)'((POST_CNT > 0) ? POST_CNT - 1 : 0);
    localparam logic [AW:0]   CNT_LAST  = (AW+1)'(DEPTH - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PRE       = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_POST      = 3'd3,
        S_READ      = 3'd4
    } state_e;

    state_e                     state_q, state_d;
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [AW:0]                cnt_q, cnt_d;
    logic [DECIM_BITS-1:0]      dcnt_q, dcnt_d;
    logic [DECIM_BITS-1:0]      decim_q, decim_d;
    logic [CH_W-1:0]            trig_ch_q, trig_ch_d;
    logic signed [SIG_BITS-1:0] level_q, level_d;
    logic                       fall_q, fall_d;
    logic signed [SIG_BITS-1:0] prev_q, prev_d;
    logic                       rd_valid_q, rd_valid_d;
    logic                       rd_last_q, rd_last_d;
    logic [TIME_BITS-1:0]       rd_time_q, rd_time_d;
    logic [N_CH*SIG_BITS-1:0]   rd_sig_q, rd_sig_d;
    logic                       done_q, done_d;

    logic [REC_W-1:0]           mem [DEPTH];
    logic [REC_W-1:0]           rd_word;
    logic                       mem_we;
    logic                       capturing, accept, crossing, load;
    logic signed [SIG_BITS-1:0] cur_s;
    logic [AW-1:0]              trig_idx;

    assign rd_word = mem[rd_ptr_q];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        dcnt_d     = dcnt_q;
        decim_d    = decim_q;
        trig_ch_d  = trig_ch_q;
        level_d    = level_q;
        fall_d     = fall_q;
        prev_d     = prev_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_time_d  = rd_time_q;
        rd_sig_d   = rd_sig_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        load       = 1'b0;
        trig_idx   = wr_ptr_q;

        capturing = (state_q == S_PRE) || (state_q == S_WAIT_TRIG) || (state_q == S_POST);
        accept    = capturing && valid_in && (dcnt_q == '0);
        cur_s     = sig[trig_ch_q*SIG_BITS +: SIG_BITS];
        crossing  = fall_q ? ((prev_q > level_q) && (cur_s <= level_q))
                           : ((prev_q < level_q) && (cur_s >= level_q));

        if (capturing && valid_in) begin
            dcnt_d = (dcnt_q == decim_q) ? '0 : dcnt_q + 1'b1;
        end
        if (accept) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
            prev_d   = cur_s;
        end

        unique case (state_q)
            S_IDLE: begin
                if (arm) begin
                    state_d   = S_PRE;
                    decim_d   = decim;
                    trig_ch_d = trig_ch;
                    level_d   = trig_level;
                    fall_d    = trig_fall;
                    wr_ptr_d  = '0;
                    dcnt_d    = '0;
                    cnt_d     = '0;
                end
            end
            S_PRE: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_WAIT_TRIG;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT_TRIG: begin
                // A forced trigger with no sample this cycle anchors on the last written entry.
                if ((accept && crossing) || force_trig) begin
                    trig_idx = accept ? wr_ptr_q : wr_ptr_q - 1'b1;
                    rd_ptr_d = trig_idx - PRE_OFF;
                    cnt_d    = '0;
                    state_d  = (POST_CNT == 0) ? S_READ : S_POST;
                end
            end
            S_POST: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == POST_LAST) begin
                        state_d = S_READ;
                        cnt_d   = '0;
                    end
                end
            end
            S_READ: begin
                // cnt counts records loaded into the output register.
                load = (cnt_q != CNT_FULL) && (!rd_valid_q || rd_ready);
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                end
                if (load) begin
                    rd_valid_d = 1'b1;
                    rd_time_d  = rd_word[REC_W-1 -: TIME_BITS];
                    rd_sig_d   = rd_word[N_CH*SIG_BITS-1:0];
                    rd_last_d  = (cnt_q == CNT_LAST);
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
                if (rd_valid_q && rd_ready && rd_last_q) begin
                    state_d   = S_IDLE;
                    rd_last_d = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            decim_q    <= '0;
            trig_ch_q  <= '0;
            level_q    <= '0;
            fall_q     <= 1'b0;
            prev_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_time_q  <= '0;
            rd_sig_q   <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            decim_q    <= decim_d;
            trig_ch_q  <= trig_ch_d;
            level_q    <= level_d;
            fall_q     <= fall_d;
            prev_q     <= prev_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_time_q  <= rd_time_d;
            rd_sig_q   <= rd_sig_d;
            done_q     <= done_d;
        end
    end

    // NOTE: the sample store has no reset; pointers decide which entries are ever read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= {time_curr, sig};
        end
    end

    assign state    = state_q;
    assign rd_valid = rd_valid_q;
    assign rd_last  = rd_last_q;
    assign rd_time  = rd_time_q;
    assign rd_sig   = rd_sig_q;
    assign done     = done_q;

endmodule
